// File: rtl/hrm_pkg.sv
// Shared types and constants for the program loader.
// State CSUM exists only when PROG_LOADER_CHECKSUM_EN is defined.
package hrm_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned SIZE_DEFAULT = 256;
  localparam logic [DATA_W-1:0] SYNC_DEFAULT = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_ERR  = 3'd4
  } state_e;

  // Frame-in-progress states
  function automatic logic is_busy(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
        || (s == ST_CSUM)
`endif
        ;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface prog_loader_if;
  import hrm_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing program memory while holding the CPU.
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import hrm_pkg::*;
#(
  parameter int unsigned        SIZE = SIZE_DEFAULT,
  parameter logic [DATA_W-1:0]  SYNC = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      rx,
  output logic [DATA_W-1:0] wAddr,
  output logic [DATA_W-1:0] din,
  output logic              write_en,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

  state_e             state_q, state_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [DATA_W-1:0]  addr_q, addr_n;
  logic               rx_ready_q, rx_ready_n;
  logic [DATA_W-1:0]  waddr_n, din_n;
  logic               write_en_n, cpu_hold_n, busy_n, done_n, err_n;
  logic               acc_c;
  logic [CNT_W-1:0]   len_c;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_q, csum_n;
`endif

  assign rx.rx_ready = rx_ready_q;
  assign acc_c       = rx.rx_valid & rx_ready_q;
  assign len_c       = CNT_W'(rx.rx_data) + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    count_n    = count_q;
    addr_n     = addr_q;
    waddr_n    = wAddr;
    din_n      = din;
    write_en_n = 1'b0;
    cpu_hold_n = cpu_hold;
    done_n     = 1'b0;
    err_n      = err;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_n     = csum_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (acc_c && rx.rx_data == SYNC) begin
          state_n    = ST_LEN;
          cpu_hold_n = 1'b1;
        end
      end
      ST_LEN: begin
        if (acc_c) begin
          if (len_c > SIZE_C) begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end else begin
            state_n = ST_DATA;
            count_n = len_c;
            addr_n  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_n  = '0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (acc_c) begin
          write_en_n = 1'b1;
          waddr_n    = addr_q;
          din_n      = rx.rx_data;
          addr_n     = addr_q + DATA_W'(1);
          count_n    = count_q - CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_n     = csum_q + rx.rx_data;
          if (count_q == CNT_W'(1)) state_n = ST_CSUM;
`else
          if (count_q == CNT_W'(1)) begin
            state_n    = ST_IDLE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (acc_c) begin
          if (rx.rx_data == csum_q) begin
            state_n    = ST_IDLE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end
        end
      end
`endif
      ST_ERR: begin
        if (err_clr) begin
          state_n    = ST_IDLE;
          err_n      = 1'b0;
          cpu_hold_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n     = is_busy(state_n);
    rx_ready_n = (state_n != ST_ERR);
  end

  // State and registered outputs; reset also kills a write pending this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      rx_ready_q <= 1'b1;
      wAddr      <= '0;
      din        <= '0;
      write_en   <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      addr_q     <= addr_n;
      rx_ready_q <= rx_ready_n;
      wAddr      <= waddr_n;
      din        <= din_n;
      write_en   <= write_en_n;
      cpu_hold   <= cpu_hold_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: SIZE=256 and SIZE=16 instances, frame-level model.
module tb_prog_loader;

  localparam logic [7:0] SYNC_B = 8'h55;
  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         dut;
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_clr;
  int         sel;

  logic [7:0] w_addr [2];
  logic [7:0] din_o  [2];
  logic       we     [2];
  logic       hold   [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       err_o  [2];

  prog_loader_if rx0 ();
  prog_loader_if rx1 ();

  assign rx0.rx_data  = drv_data;
  assign rx1.rx_data  = drv_data;
  assign rx0.rx_valid = drv_valid && (sel == 0);
  assign rx1.rx_valid = drv_valid && (sel == 1);

  prog_loader #(.SIZE(256)) u_dut (
    .clk(clk), .rst(rst), .rx(rx0),
    .wAddr(w_addr[0]), .din(din_o[0]), .write_en(we[0]),
    .cpu_hold(hold[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
    .err_clr(drv_clr && (sel == 0))
  );

  prog_loader #(.SIZE(16)) u_dut16 (
    .clk(clk), .rst(rst), .rx(rx1),
    .wAddr(w_addr[1]), .din(din_o[1]), .write_en(we[1]),
    .cpu_hold(hold[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
    .err_clr(drv_clr && (sel == 1))
  );

  int   nvec  = 0;
  int   nfail = 0;
  ev_t  exp_q[$];
  logic err_seen [2] = '{1'b0, 1'b0};
  int   run_len  = 0;
  int   last_run = 0;

  logic [7:0] f_noise[$];
  logic [7:0] f_data[$];
  logic [7:0] f_len;
  logic [7:0] f_cs;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input int d, input int k, input logic [7:0] a, input logic [7:0] dt);
    ev_t e;
    nvec++;
    if (exp_q.size() == 0) begin
      nfail++;
      $display("FAIL unexpected_event: dut%0d kind %0d addr %02h data %02h, none expected", d, k, a, dt);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || (k == K_WR && (e.addr != a || e.data != dt))) begin
        nfail++;
        $display("FAIL event: got dut%0d kind %0d addr %02h data %02h, expected dut%0d kind %0d addr %02h data %02h",
                 d, k, a, dt, e.dut, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every write, done pulse and err rise must match the head of the queue
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d])                      check_ev(d, K_WR, w_addr[d], din_o[d]);
      if (done_o[d])                  check_ev(d, K_DONE, 8'h00, 8'h00);
      if (err_o[d] && !err_seen[d])   check_ev(d, K_ERR, 8'h00, 8'h00);
      err_seen[d] = err_o[d];
    end
    if (we[0]) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] dt);
    ev_t e;
    e.dut = sel; e.kind = k; e.addr = a; e.data = dt;
    exp_q.push_back(e);
  endfunction

  function automatic logic rdy(input int s);
    return (s == 1) ? rx1.rx_ready : rx0.rx_ready;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    drv_data  = b;
    drv_valid = 1'b1;
    while (!rdy(sel) && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("rx_ready_timeout", int'(rdy(sel)), 1);
    tick(1);
  endtask

  task automatic gap(input bit en);
    int n;
    if (en) begin
      n = $urandom_range(0, 2);
      if (n != 0) begin drv_valid = 1'b0; tick(n); end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin tick(1); t++; end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_err();
    drv_clr = 1'b1;
    tick(1);
    drv_clr = 1'b0;
    chk("clr_err",      int'(err_o[sel]), 0);
    chk("clr_cpu_hold", int'(hold[sel]), 0);
    chk("clr_rx_ready", int'(rdy(sel)), 1);
  endtask

  // Frame-level reference: writes i->data[i], then done (or err on bad length/checksum)
  task automatic run_frame(input bit gaps);
    int  size = (sel == 1) ? 16 : 256;
    int  sum  = 0;
    bit  bad  = 1'b0;
    foreach (f_noise[i]) begin gap(gaps); send(f_noise[i]); end
    gap(gaps); send(SYNC_B);
    gap(gaps);
    if (int'(f_len) + 1 > size) begin
      push_ev(K_ERR, 8'h00, 8'h00);
      send(f_len);
      drv_valid = 1'b0;
      drain();
      chk("lenerr_err",      int'(err_o[sel]), 1);
      chk("lenerr_cpu_hold", int'(hold[sel]), 1);
      chk("lenerr_rx_ready", int'(rdy(sel)), 0);
      chk("lenerr_busy",     int'(busy_o[sel]), 0);
      clear_err();
      return;
    end
    send(f_len);
    chk("frame_cpu_hold", int'(hold[sel]), 1);
    chk("frame_busy",     int'(busy_o[sel]), 1);
    for (int i = 0; i <= int'(f_len); i++) begin
      push_ev(K_WR, 8'(i), f_data[i]);
      gap(gaps);
      send(f_data[i]);
      sum += int'(f_data[i]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    bad = (f_cs != 8'(sum));
    push_ev(bad ? K_ERR : K_DONE, 8'h00, 8'h00);
    gap(gaps);
    send(f_cs);
`else
    push_ev(K_DONE, 8'h00, 8'h00);
`endif
    drv_valid = 1'b0;
    drain();
    if (bad) begin
      chk("csumerr_err",      int'(err_o[sel]), 1);
      chk("csumerr_cpu_hold", int'(hold[sel]), 1);
      chk("csumerr_rx_ready", int'(rdy(sel)), 0);
      clear_err();
    end else begin
      chk("end_cpu_hold", int'(hold[sel]), 0);
      chk("end_busy",     int'(busy_o[sel]), 0);
      chk("end_err",      int'(err_o[sel]), 0);
      chk("end_rx_ready", int'(rdy(sel)), 1);
    end
  endtask

  task automatic rand_frame();
    logic [7:0] b;
    int s = 0;
    sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
    f_noise.delete();
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == SYNC_B) b = 8'h00;
      f_noise.push_back(b);
    end
    f_len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 12));
    f_data.delete();
    for (int i = 0; i <= int'(f_len); i++) begin
      b = 8'($urandom);
      f_data.push_back(b);
      s += int'(b);
    end
    f_cs = ($urandom_range(0, 3) == 0) ? 8'(s + $urandom_range(1, 255)) : 8'(s);
    run_frame(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wAddr"},    int'(w_addr[0]), 0);
    chk({tag, "_din"},      int'(din_o[0]), 0);
    chk({tag, "_write_en"}, int'(we[0]), 0);
    chk({tag, "_cpu_hold"}, int'(hold[0]), 0);
    chk({tag, "_busy"},     int'(busy_o[0]), 0);
    chk({tag, "_done"},     int'(done_o[0]), 0);
    chk({tag, "_err"},      int'(err_o[0]), 0);
    chk({tag, "_rx_ready"}, int'(rx0.rx_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drv_data = 8'h00; drv_valid = 1'b0; drv_clr = 1'b0; sel = 0;
    tick(2);
    check_reset_outputs("reset");
    chk("reset_rx_ready16", int'(rx1.rx_ready), 1);
    rst = 1'b0;
    tick(1);

    // Three-word frame with correct checksum
    sel = 0; f_noise.delete(); f_len = 8'h02; f_data = '{8'h11, 8'h22, 8'h33}; f_cs = 8'h66;
    run_frame(1'b0);

    // Single word, wrong checksum
    f_len = 8'h00; f_data = '{8'hAA}; f_cs = 8'h00;
    run_frame(1'b0);

    // Leading noise; err_clr held high must not disturb a normal frame
    drv_clr = 1'b1;
    f_noise = '{8'h00, 8'hFF, 8'h13}; f_len = 8'h00; f_data = '{8'h7E}; f_cs = 8'h7E;
    run_frame(1'b0);
    drv_clr = 1'b0;
    f_noise.delete();

    // SIZE=16: L=0x10 overflows, L=0x0F fills the memory exactly
    sel = 1; f_len = 8'h10;
    run_frame(1'b0);
    f_len = 8'h0F; f_data.delete();
    begin
      int s = 0;
      for (int i = 0; i < 16; i++) begin f_data.push_back(8'(i * 7 + 1)); s += i * 7 + 1; end
      f_cs = 8'(s);
    end
    run_frame(1'b1);

    // Full 256-word frame back-to-back
    sel = 0; f_len = 8'hFF; f_data.delete();
    begin
      int s = 0;
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin b = 8'($urandom); f_data.push_back(b); s += int'(b); end
      f_cs = 8'(s);
    end
    run_frame(1'b0);
    tick(2);
    chk("full_frame_write_run", last_run, 256);

    // Reset after the third data byte of a 5-word frame; the reset-cycle byte is dropped
    sel = 0;
    send(SYNC_B); send(8'h04);
    push_ev(K_WR, 8'h00, 8'hA1); send(8'hA1);
    push_ev(K_WR, 8'h01, 8'hB2); send(8'hB2);
    push_ev(K_WR, 8'h02, 8'hC3); send(8'hC3);
    drv_data = 8'hD4; drv_valid = 1'b1; rst = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    rst = 1'b0; drv_valid = 1'b0;
    tick(1);
    drain();
    f_len = 8'h01; f_data = '{8'h5A, 8'hA5}; f_cs = 8'hFF;
    run_frame(1'b0);

    repeat (40) rand_frame();

    tick(5);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
